// File: rtl/bp_resolve_tracker_if.sv
// Signal bundle between the frontend/execute stages and the resolve tracker:
// prediction push, in-order branch resolve, and the registered meta-predictor update.
interface bp_resolve_tracker_if #(
    parameter int unsigned VLEN            = 32,
    parameter int unsigned INSTR_PER_FETCH = 2
);
    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    logic                       push_valid_i;
    logic                       push_ready_o;
    logic [VLEN-1:0]            push_pc_i;
    logic                       push_local_taken_i;
    logic                       push_global_taken_i;
    logic                       resolve_valid_i;
    logic [VLEN-1:0]            resolve_pc_i;
    logic                       resolve_taken_i;
    bht_update_t                bht_update_o;
    logic [INSTR_PER_FETCH-1:0] local_correct_o;
    logic [INSTR_PER_FETCH-1:0] global_correct_o;

    modport master (
        output push_valid_i, push_pc_i, push_local_taken_i, push_global_taken_i,
        output resolve_valid_i, resolve_pc_i, resolve_taken_i,
        input  push_ready_o, bht_update_o, local_correct_o, global_correct_o
    );

    modport slave (
        input  push_valid_i, push_pc_i, push_local_taken_i, push_global_taken_i,
        input  resolve_valid_i, resolve_pc_i, resolve_taken_i,
        output push_ready_o, bht_update_o, local_correct_o, global_correct_o
    );
endinterface

// File: rtl/bp_resolve_tracker.sv
// Holds local/global fetch-time predictions per branch in a circular FIFO and, on
// in-order resolve, emits a one-cycle update with per-slot predictor-correct flags.
module bp_resolve_tracker #(
    parameter int unsigned VLEN            = 32,
    parameter bit          RVC             = 1'b1,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter bit          DebugEn         = 1'b1,
    parameter int unsigned DEPTH           = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     debug_mode_i,
    bp_resolve_tracker_if.slave      bus,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     mismatch_o
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SLOT_W = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;

    logic [DEPTH-1:0][VLEN-1:0] pc_q;
    logic [DEPTH-1:0]           local_q;
    logic [DEPTH-1:0]           global_q;
    logic [PTR_W-1:0]           head_q, tail_q;
    logic [CNT_W-1:0]           count_q, count_d;

    logic                       push_ready, push_fire, pop, hit, upd;
    logic [SLOT_W-1:0]          slot;
    logic [INSTR_PER_FETCH-1:0] lc_d, gc_d;

    logic [VLEN+1:0]            upd_q;
    logic [INSTR_PER_FETCH-1:0] lc_q, gc_q;
    logic                       mm_q;

    // Ready looks only at registered occupancy, never at a same-cycle pop.
    assign push_ready = (count_q != CNT_W'(DEPTH)) && !flush_i;
    assign push_fire  = bus.push_valid_i && push_ready;
    assign pop        = bus.resolve_valid_i && (count_q != '0);
    assign hit        = pop && (pc_q[head_q] == bus.resolve_pc_i);
    assign upd        = hit && !(DebugEn && debug_mode_i);

    always_comb begin
        count_d = count_q;
        if (push_fire && !pop)      count_d = count_q + 1'b1;
        else if (!push_fire && pop) count_d = count_q - 1'b1;
    end

    always_comb begin
        slot = '0;
        if (RVC && INSTR_PER_FETCH > 1) slot = bus.resolve_pc_i[SLOT_W:1];
    end

    for (genvar s = 0; s < INSTR_PER_FETCH; s++) begin : g_slot
        assign lc_d[s] = upd && (slot == SLOT_W'(s)) && (local_q[head_q]  == bus.resolve_taken_i);
        assign gc_d[s] = upd && (slot == SLOT_W'(s)) && (global_q[head_q] == bus.resolve_taken_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop)       head_q <= head_q + 1'b1;
            if (push_fire) tail_q <= tail_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= '0;
            local_q  <= '0;
            global_q <= '0;
        end else if (push_fire) begin
            pc_q[tail_q]     <= bus.push_pc_i;
            local_q[tail_q]  <= bus.push_local_taken_i;
            global_q[tail_q] <= bus.push_global_taken_i;
        end
    end

    // Resolve is evaluated ahead of flush, so a flushing cycle still reports its update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_q <= '0;
            lc_q  <= '0;
            gc_q  <= '0;
            mm_q  <= 1'b0;
        end else begin
            upd_q <= upd ? {1'b1, bus.resolve_pc_i, bus.resolve_taken_i} : '0;
            lc_q  <= lc_d;
            gc_q  <= gc_d;
            mm_q  <= pop && !hit;
        end
    end

    assign bus.push_ready_o     = push_ready;
    assign bus.bht_update_o     = upd_q;
    assign bus.local_correct_o  = lc_q;
    assign bus.global_correct_o = gc_q;
    assign count_o              = count_q;
    assign mismatch_o           = mm_q;
endmodule

// File: tb/tb_bp_resolve_tracker.sv
// Bench for bp_resolve_tracker: directed vector table, corner sequences, and random
// traffic checked against a queue-based model of the tracked predictions.
module tb_bp_resolve_tracker;
    localparam int VLEN = 32, IPF = 2, DEPTH = 8, CW = 4;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, dbg = 1'b0;
    logic [CW-1:0] count;
    logic mm;

    bp_resolve_tracker_if #(.VLEN(VLEN), .INSTR_PER_FETCH(IPF)) bus ();

    bp_resolve_tracker #(
        .VLEN(VLEN), .RVC(1'b1), .INSTR_PER_FETCH(IPF), .DebugEn(1'b1), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .debug_mode_i(dbg),
        .bus(bus), .count_o(count), .mismatch_o(mm)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic lt; logic gt; } ent_t;
    ent_t mq[$];

    typedef struct {
        logic pv; logic [31:0] ppc; logic plt; logic pgt;
        logic rv; logic [31:0] rpc; logic rt; logic fl; logic db;
        logic ev; logic [31:0] epc; logic et; logic [1:0] elc; logic [1:0] egc; logic emm; int ecnt;
    } vec_t;
    vec_t tbl[$];

    int tests = 0, fails = 0;
    logic e_v, e_t, e_mm, exp_rdy;
    logic [31:0] e_pc;
    logic [IPF-1:0] e_lc, e_gc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic pv, input logic [31:0] ppc, input logic plt, input logic pgt,
                          input logic rv, input logic [31:0] rpc, input logic rt,
                          input logic fl, input logic db);
        bus.push_valid_i = pv; bus.push_pc_i = ppc;
        bus.push_local_taken_i = plt; bus.push_global_taken_i = pgt;
        bus.resolve_valid_i = rv; bus.resolve_pc_i = rpc; bus.resolve_taken_i = rt;
        flush = fl; dbg = db;
    endtask

    // One clock: apply inputs, check ready, advance the model, check registered outputs.
    task automatic cyc(input logic pv, input logic [31:0] ppc, input logic plt, input logic pgt,
                       input logic rv, input logic [31:0] rpc, input logic rt,
                       input logic fl, input logic db);
        ent_t ent;
        int slot;
        set_in(pv, ppc, plt, pgt, rv, rpc, rt, fl, db);
        #1;
        exp_rdy = (mq.size() != DEPTH) && !fl;
        chk("push_ready", bus.push_ready_o, exp_rdy);
        e_v = 0; e_pc = '0; e_t = 0; e_lc = '0; e_gc = '0; e_mm = 0;
        if (rv && mq.size() > 0) begin
            ent = mq.pop_front();
            if (ent.pc == rpc) begin
                if (!db) begin
                    e_v = 1; e_pc = rpc; e_t = rt;
                    slot = (rpc >> 1) % IPF;
                    if (ent.lt == rt) e_lc[slot] = 1'b1;
                    if (ent.gt == rt) e_gc[slot] = 1'b1;
                end
            end else e_mm = 1;
        end
        if (pv && exp_rdy) mq.push_back('{ppc, plt, pgt});
        if (fl) mq.delete();
        @(posedge clk); #1;
        chk("upd_valid", bus.bht_update_o.valid, e_v);
        chk("upd_pc", bus.bht_update_o.pc, e_pc);
        chk("upd_taken", bus.bht_update_o.taken, e_t);
        chk("local_correct", bus.local_correct_o, e_lc);
        chk("global_correct", bus.global_correct_o, e_gc);
        chk("mismatch", mm, e_mm);
        chk("count", count, mq.size());
    endtask

    task automatic idle();
        cyc(0, '0, 0, 0, 0, '0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic plt, pgt, rt, pv, rv, fl, db;
        logic [31:0] ppc, rpc;

        // pv ppc plt pgt rv rpc rt fl db | ev epc et elc egc emm cnt
        tbl.push_back('{1, 32'h80000004, 1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 1});
        tbl.push_back('{0, 32'h0,        0, 0, 1, 32'h80000004, 1, 0, 0, 1, 32'h80000004, 1, 2'b01, 2'b00, 0, 0});
        tbl.push_back('{1, 32'h100,      0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 1});
        tbl.push_back('{0, 32'h0,        0, 0, 1, 32'h104,      0, 0, 0, 0, 32'h0,        0, 2'b00, 2'b00, 1, 0});
        tbl.push_back('{0, 32'h0,        0, 0, 1, 32'h200,      1, 0, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 0});
        tbl.push_back('{1, 32'h80000006, 0, 1, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 1});
        tbl.push_back('{0, 32'h0,        0, 0, 1, 32'h80000006, 1, 0, 0, 1, 32'h80000006, 1, 2'b00, 2'b10, 0, 0});
        tbl.push_back('{1, 32'h40,       1, 1, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 1});
        tbl.push_back('{0, 32'h0,        0, 0, 1, 32'h40,       1, 0, 1, 0, 32'h0,        0, 2'b00, 2'b00, 0, 0});
        tbl.push_back('{1, 32'h50,       0, 1, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 1});
        tbl.push_back('{1, 32'h60,       1, 0, 1, 32'h50,       0, 0, 0, 1, 32'h50,       0, 2'b01, 2'b00, 0, 1});
        tbl.push_back('{0, 32'h0,        0, 0, 1, 32'h60,       0, 0, 0, 1, 32'h60,       0, 2'b00, 2'b01, 0, 0});

        set_in(0, '0, 0, 0, 0, '0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_ready", bus.push_ready_o, 1);
        chk("rst_upd", bus.bht_update_o, '0);
        chk("rst_lc", bus.local_correct_o, 0);
        chk("rst_gc", bus.global_correct_o, 0);
        chk("rst_mm", mm, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].pv, tbl[i].ppc, tbl[i].plt, tbl[i].pgt, tbl[i].rv, tbl[i].rpc,
                tbl[i].rt, tbl[i].fl, tbl[i].db);
            chk("tbl_valid", bus.bht_update_o.valid, tbl[i].ev);
            chk("tbl_pc", bus.bht_update_o.pc, tbl[i].epc);
            chk("tbl_taken", bus.bht_update_o.taken, tbl[i].et);
            chk("tbl_lc", bus.local_correct_o, tbl[i].elc);
            chk("tbl_gc", bus.global_correct_o, tbl[i].egc);
            chk("tbl_mm", mm, tbl[i].emm);
            chk("tbl_count", count, tbl[i].ecnt);
        end

        // Fill to full, then a push+pop in one cycle only pops; then run across the wrap.
        for (int i = 0; i < DEPTH; i++) cyc(1, 32'h1000 + 32'(4 * i), i[0], ~i[0], 0, '0, 0, 0, 0);
        chk("full_count", count, DEPTH);
        chk("full_ready", bus.push_ready_o, 0);
        cyc(1, 32'h2000, 1, 1, 1, 32'h1000, 1, 0, 0);
        chk("full_pushpop_count", count, DEPTH - 1);
        for (int i = 0; i < 20; i++) begin
            plt = 1'($urandom_range(0, 1)); pgt = 1'($urandom_range(0, 1)); rt = 1'($urandom_range(0, 1));
            cyc(1, 32'h3000 + 32'(4 * i), plt, pgt, 1, mq[0].pc, rt, 0, 0);
        end

        // Flush with a matching resolve: update still emitted, queued entries and push discarded.
        cyc(0, '0, 0, 0, 0, '0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'h500 + 32'(4 * i), 1, 0, 0, '0, 0, 0, 0);
        chk("flush_pre_count", count, 3);
        cyc(1, 32'h600, 1, 1, 1, 32'h500, 1, 1, 0);
        chk("flush_upd_valid", bus.bht_update_o.valid, 1);
        chk("flush_upd_pc", bus.bht_update_o.pc, 32'h500);
        chk("flush_count", count, 0);
        idle();
        chk("flush_push_refused", count, 0);

        // Asynchronous reset with five entries queued and a resolve pending.
        for (int i = 0; i < 5; i++) cyc(1, 32'h700 + 32'(4 * i), 1, 1, 0, '0, 0, 0, 0);
        chk("prerst_count", count, 5);
        set_in(0, '0, 0, 0, 1, 32'h700, 1, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_ready", bus.push_ready_o, 1);
        chk("arst_upd", bus.bht_update_o, '0);
        @(posedge clk); #1;
        chk("arst_no_update", bus.bht_update_o, '0);
        chk("arst_lc", bus.local_correct_o, 0);
        chk("arst_mm", mm, 0);
        set_in(0, '0, 0, 0, 0, '0, 0, 0, 0);
        mq.delete();
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 500; n++) begin
            pv  = ($urandom_range(0, 3) != 0);
            ppc = $urandom & 32'hFFFF_FFFE;
            plt = 1'($urandom_range(0, 1)); pgt = 1'($urandom_range(0, 1));
            rv  = ($urandom_range(0, 2) == 0);
            rpc = (mq.size() > 0 && $urandom_range(0, 9) != 0) ? mq[0].pc : ($urandom & 32'hFFFF_FFFE);
            rt  = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 39) == 0);
            db  = ($urandom_range(0, 7) == 0);
            cyc(pv, ppc, plt, pgt, rv, rpc, rt, fl, db);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bp_resolve_tracker.md
# bp_resolve_tracker

Tracks, per fetched branch, the predictions the local and global predictors made at fetch time. When a branch resolves in execute, it pops the matching entry and produces a registered update for the meta branch predictor. The update carries the resolved outcome and one-hot per-slot `local_correct` / `global_correct` flags. The block sits between the frontend prediction stage (writer side) and the meta predictor's update port (reader side).

## Interface
- `CVA6Cfg`, `config_pkg::cva6_cfg_empty`: core configuration; uses `VLEN`, `RVC`, `INSTR_PER_FETCH`, `DebugEn`.
- `bht_update_t`, `logic`: update struct; fields `valid`, `pc[VLEN-1:0]`, `taken`.
- `DEPTH`, 8: tracking FIFO entries; power of two, ≥2.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: discard all tracked entries.
- `debug_mode_i` in 1: CSR debug state.
- `push_valid_i` in 1: frontend records a predicted branch.
- `push_ready_o` out 1: entry can be accepted.
- `push_pc_i` in VLEN: branch PC.
- `push_local_taken_i` in 1: local predictor direction.
- `push_global_taken_i` in 1: global predictor direction.
- `resolve_valid_i` in 1: execute resolved a conditional branch (program order).
- `resolve_pc_i` in VLEN: resolved PC.
- `resolve_taken_i` in 1: actual direction.
- `bht_update_o` out bht_update_t: update to meta predictor.
- `local_correct_o` out INSTR_PER_FETCH: one-hot at slot, local predictor was right.
- `global_correct_o` out INSTR_PER_FETCH: one-hot at slot, global predictor was right.
- `count_o` out $clog2(DEPTH)+1: occupied entries.
- `mismatch_o` out 1: pulse, head PC ≠ resolve PC.

## Operation
- Circular FIFO: head/tail pointers of $clog2(DEPTH) bits, wrap modulo DEPTH. Count register is $clog2(DEPTH)+1 bits.
- Entry fields: pc, local_taken, global_taken.
- `push_ready_o = (count != DEPTH) && !flush_i`. It is combinational and does not depend on a same-cycle pop.
- A push is accepted when `push_valid_i && push_ready_o`. It writes the tail, and the tail increments.
- Resolve with `count == 0` is ignored: no update, no mismatch, no pop.
- Resolve with `count > 0` always pops the head.
  - Head pc == `resolve_pc_i`: update generated.
  - Otherwise: no update, and `mismatch_o` pulses.
- Update generation (registered):
  - `bht_update_o.valid = 1`, with pc and taken taken from the resolve inputs.
  - slot = `pc[$clog2(INSTR_PER_FETCH)+OFFSET-1:OFFSET]` when RVC=1 (OFFSET=1), otherwise slot = 0 (OFFSET=2).
  - `local_correct_o[slot] = (local_taken == taken)`.
  - `global_correct_o[slot] = (global_taken == taken)`.
  - All other bits are 0.
- Debug suppression: when `DebugEn && debug_mode_i`, the head still pops, but `bht_update_o.valid = 0` and the correct vectors are 0.
- Simultaneous push and pop: both happen, and count is unchanged.
- Flush:
  - The next state is head = tail = count = 0.
  - A resolve in the same cycle still produces its update (resolve is evaluated before the flush).
  - A push in the same cycle is refused because ready is low.
- When neither an update nor a mismatch occurs, the output registers return to 0 every cycle. Outputs are never held.

## Timing
- Reset values: `bht_update_o = '0`, `local_correct_o = '0`, `global_correct_o = '0`, `mismatch_o = 0`, `count_o = 0`, `push_ready_o = 1` (while `flush_i = 0`). Pointers are 0.
- A reset asserted mid-operation clears everything asynchronously, and no pending update is emitted.
- Resolve in cycle N produces `bht_update_o`, the correct vectors, and `mismatch_o` in cycle N+1, each as a single-cycle pulse.
- A push in cycle N becomes visible in `count_o` at N+1. It can be resolved no earlier than N+1.
- `count_o` and `push_ready_o` reflect registered state, so there is no combinational path from resolve to push_ready.
- Full: `count = DEPTH` gives `push_ready_o = 0`, even when a pop occurs in the same cycle.
- Throughput: one push and one resolve per cycle.

## Test plan
- Push pc=0x80000004 (local=1, global=0), then resolve the same pc with taken=1 at cycle N. At N+1: update valid, pc 0x80000004, taken 1; with RVC and INSTR_PER_FETCH=2, slot 0, so `local_correct=2'b01`, `global_correct=2'b00`. count returns to 0.
- Fill 8 entries. Then `push_ready_o=0` and `count_o=8`. A push plus resolve in one cycle pops only, so count=7. Continue 20 push/resolve pairs across the pointer wrap; every update pc matches in FIFO order.
- Push pc=0x100, then resolve pc=0x104. At N+1: `mismatch_o=1`, `bht_update_o.valid=0`, count=0.
- Queue 3 entries, then assert `flush_i` together with a matching resolve. The update is still emitted at N+1, then count=0. The push presented during the flush is refused.
- With DebugEn and `debug_mode_i=1`, a matching resolve gives count decremented, `bht_update_o.valid=0`, and correct vectors 0.
- Resolve with an empty queue: no outputs change and count stays 0. Assert `rst_ni=0` with 5 entries queued: count=0 immediately, and all outputs are 0.
